// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic pipeline stage: FSM state encodings.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    PIPE_ST_EMPTY = 2'b00,
    PIPE_ST_BUSY  = 2'b01,
    PIPE_ST_FULL  = 2'b10
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_entry.sv
// One {ctrl,data} holding register for the skid stage, with load enable and
// synchronous clear (clear wins over load).
module pipe_stage_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Hold the entry; clear drops it, load captures a new one.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: valid/ready handshake with a main entry and a skid
// entry, full throughput, o_ready decoded straight from the state register.
// Control bundle is zeroed whenever nothing is presented downstream.
// Optional feature macro: PIPE_SKID_PERF_CNT_EN adds saturating stall/bubble
// counters (o_stall_cnt, o_bubble_cnt); without it those ports do not exist.
//
// state | meaning
// EMPTY | no entry held
// BUSY  | main entry valid, skid empty
// FULL  | main and skid entries valid, input blocked
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int CTRL_WIDTH = 10,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [DATA_WIDTH-1:0] o_data
`ifdef PIPE_SKID_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt,
  output logic [CNT_WIDTH-1:0]  o_bubble_cnt
`endif
);

  localparam int EW = CTRL_WIDTH + DATA_WIDTH;

  pipe_state_e r_state;
  pipe_state_e w_next;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_main_load;
  logic        w_skid_load;
  logic        w_main_from_skid;
  logic        w_clr;
  logic [EW-1:0] w_in_entry;
  logic [EW-1:0] w_main_d;
  logic [EW-1:0] w_main_q;
  logic [EW-1:0] w_skid_q;

  assign o_valid    = (r_state != PIPE_ST_EMPTY);
  assign o_ready    = (r_state != PIPE_ST_FULL);
  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;
  assign w_clr      = i_rst | i_flush;

  // State register; reset and flush both discard everything held.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= PIPE_ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and entry load strobes from the two handshakes.
  always_comb begin
    w_next           = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      PIPE_ST_EMPTY: begin
        if (w_in_fire) begin
          w_next      = PIPE_ST_BUSY;
          w_main_load = 1'b1;
        end
      end
      PIPE_ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          w_next      = PIPE_ST_FULL;
          w_skid_load = 1'b1;
        end else if (w_out_fire) begin
          w_next = PIPE_ST_EMPTY;
        end
      end
      PIPE_ST_FULL: begin
        // o_ready is low here, so only the skid entry can advance.
        if (w_out_fire) begin
          w_next           = PIPE_ST_BUSY;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_next = PIPE_ST_EMPTY;
      end
    endcase
  end

  assign w_in_entry = {i_ctrl, i_data};
  assign w_main_d   = w_main_from_skid ? w_skid_q : w_in_entry;

  pipe_stage_entry #(.W(EW)) u_main (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  pipe_stage_entry #(.W(EW)) u_skid (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_load (w_skid_load),
    .i_d    (w_in_entry),
    .o_q    (w_skid_q)
  );

  // Bubble is a guaranteed no-op downstream: ctrl gated by o_valid.
  assign o_ctrl = w_main_q[EW-1:DATA_WIDTH] & {CTRL_WIDTH{o_valid}};
  assign o_data = w_main_q[DATA_WIDTH-1:0];

`ifdef PIPE_SKID_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_bubble_cnt;

  // Saturating perf counters; flush leaves them alone, only reset clears.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (o_valid && !i_ready && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (!o_valid && (r_bubble_cnt != {CNT_WIDTH{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`else
  // Counter width has no meaning without the counters; keep it referenced.
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a long
// random handshake run, all compared against a queue-based occupancy model.
module tb_pipe_skid_stage;

  localparam int CW = 4;
  localparam int DW = 16;
  localparam int NW = 4;

  logic          clk;
  logic          i_rst;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [CW-1:0] i_ctrl;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [CW-1:0] o_ctrl;
  logic [DW-1:0] o_data;
`ifdef PIPE_SKID_PERF_CNT_EN
  logic [NW-1:0] o_stall_cnt;
  logic [NW-1:0] o_bubble_cnt;
`endif

  pipe_skid_stage #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .CNT_WIDTH(NW)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_ctrl       (i_ctrl),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_ctrl       (o_ctrl),
    .o_data       (o_data)
`ifdef PIPE_SKID_PERF_CNT_EN
    ,
    .o_stall_cnt  (o_stall_cnt),
    .o_bubble_cnt (o_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } item_t;

  item_t m_q[$];
  int    m_stall;
  int    m_bubble;
  bit    m_in_fire;
  int    total;
  int    bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most two items; input sees "not full".
  task automatic model_edge();
    int    sz;
    bit    of;
    bit    inf;
    item_t it;
    sz  = m_q.size();
    of  = (sz > 0) && i_ready;
    inf = i_valid && (sz < 2);
    m_in_fire = 1'b0;
    if (i_rst) begin
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (sz > 0 && !i_ready && m_stall < (1 << NW) - 1) m_stall++;
      if (sz == 0 && m_bubble < (1 << NW) - 1) m_bubble++;
    end
    if (i_rst || i_flush) begin
      m_q.delete();
    end else begin
      if (of) void'(m_q.pop_front());
      if (inf) begin
        it.ctrl = i_ctrl;
        it.data = i_data;
        m_q.push_back(it);
        m_in_fire = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("o_valid", 64'(o_valid), 64'(m_q.size() > 0));
    chk("o_ready", 64'(o_ready), 64'(m_q.size() < 2));
    if (m_q.size() > 0) begin
      chk("o_data", 64'(o_data), 64'(m_q[0].data));
      chk("o_ctrl", 64'(o_ctrl), 64'(m_q[0].ctrl));
    end else begin
      chk("o_ctrl_bubble", 64'(o_ctrl), 64'd0);
    end
`ifdef PIPE_SKID_PERF_CNT_EN
    chk("stall_cnt", 64'(o_stall_cnt), 64'(m_stall));
    chk("bubble_cnt", 64'(o_bubble_cnt), 64'(m_bubble));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d, input bit r);
    i_valid = v;
    i_ctrl  = c;
    i_data  = d;
    i_ready = r;
  endtask

  initial begin
    logic [DW-1:0] wr_seq;
    logic [DW-1:0] rd_seq;
    total    = 0;
    bad      = 0;
    m_stall  = 0;
    m_bubble = 0;
    i_rst    = 1'b1;
    i_flush  = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    i_rst = 1'b0;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_ctrl", 64'(o_ctrl), 64'd0);

    // Back-to-back streaming, one-cycle latency.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 4'h1, DW'(k), 1'b1);
      step();
      chk("stream_data", 64'(o_data), 64'(k));
      chk("stream_ready", 64'(o_ready), 64'd1);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    chk("stream_drain", 64'(o_valid), 64'd0);

    // Fill both entries while stalled, then drain in order.
    drive(1'b1, 4'h2, 16'hAAAA, 1'b0);
    step();
    drive(1'b1, 4'h3, 16'hBBBB, 1'b0);
    step();
    chk("full_ready", 64'(o_ready), 64'd0);
    chk("full_hold_a", 64'(o_data), 64'hAAAA);
    drive(1'b1, 4'h4, 16'hCCCC, 1'b0);
    step();
    chk("full_still_a", 64'(o_data), 64'hAAAA);
    drive(1'b0, '0, '0, 1'b1);
    step();
    chk("drain_b", 64'(o_data), 64'hBBBB);
    chk("drain_b_ctrl", 64'(o_ctrl), 64'h3);
    step();
    chk("drain_empty", 64'(o_valid), 64'd0);
    chk("drain_ready", 64'(o_ready), 64'd1);

    // Flush in FULL with a valid input that same cycle.
    drive(1'b1, 4'h5, 16'h1111, 1'b0);
    step();
    drive(1'b1, 4'h6, 16'h2222, 1'b0);
    step();
    i_flush = 1'b1;
    drive(1'b1, 4'h7, 16'hEEEE, 1'b0);
    step();
    i_flush = 1'b0;
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_ctrl", 64'(o_ctrl), 64'd0);
    chk("flush_ready", 64'(o_ready), 64'd1);
    drive(1'b0, '0, '0, 1'b1);
    step();
    chk("flush_no_ghost", 64'(o_valid), 64'd0);

    // Control bundle only visible while valid.
    drive(1'b1, 4'hF, 16'h0F0F, 1'b1);
    step();
    chk("ctrl_f", 64'(o_ctrl), 64'hF);
    drive(1'b0, 4'hF, 16'h0F0F, 1'b1);
    step();
    chk("ctrl_zero", 64'(o_ctrl), 64'h0);
    step();
    chk("ctrl_zero2", 64'(o_ctrl), 64'h0);

`ifdef PIPE_SKID_PERF_CNT_EN
    // Long stall saturates the stall counter; reset clears it.
    drive(1'b1, 4'h1, 16'h5555, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 20; k++) step();
    chk("stall_sat", 64'(o_stall_cnt), 64'hF);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("stall_clr", 64'(o_stall_cnt), 64'h0);
`endif

    // Random handshakes with an incrementing payload.
    wr_seq = '0;
    rd_seq = '0;
    for (int k = 0; k < 10000; k++) begin
      drive(($urandom_range(0, 3) != 0), CW'($urandom), wr_seq,
            ($urandom_range(0, 2) != 0));
      if (o_valid && i_ready) begin
        chk("sb_order", 64'(o_data), 64'(rd_seq));
        rd_seq++;
      end
      step();
      if (m_in_fire) wr_seq++;
    end
    chk("sb_count", 64'(DW'(rd_seq + DW'(m_q.size()))), 64'(wr_seq));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
